// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: accepts one command, applies one single-bit
// shift/rotate step per clock for the requested count, then holds the result.
module shift_sequencer #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [AMT_W-1:0] cmd_amt,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             res_err,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   typedef enum logic [2:0] {OP_LSL, OP_LSR, OP_ASR, OP_ROL, OP_ROR} op_t;

   state_t           state, state_nxt;
   op_t              op_q;
   logic [WIDTH-1:0] work_q, step_val;
   logic [AMT_W-1:0] cnt_q;
   logic             err_q;
   logic             cmd_illegal;

   assign cmd_illegal = (cmd_op > 3'(OP_ROR));

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // NOTE: every combinational output gets a default first, so no path through
   // the case statement can leave it unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (cmd_valid)
                   state_nxt = (cmd_illegal || cmd_amt == '0) ? DONE : SHIFT;
         SHIFT: if (cnt_q == AMT_W'(1)) state_nxt = DONE;
         DONE:  if (res_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      step_val = work_q;
      case (op_q)
         OP_LSL: step_val = {work_q[WIDTH-2:0], 1'b0};
         OP_LSR: step_val = {1'b0, work_q[WIDTH-1:1]};
         OP_ASR: step_val = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
         OP_ROL: step_val = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
         OP_ROR: step_val = {work_q[0], work_q[WIDTH-1:1]};
         default: step_val = work_q;
      endcase
   end

   // Illegal ops skip SHIFT entirely, so the operand reaches DONE untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         work_q <= '0;
         cnt_q  <= '0;
         op_q   <= OP_LSL;
         err_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (cmd_valid) begin
               work_q <= cmd_data;
               cnt_q  <= cmd_amt;
               op_q   <= op_t'(cmd_op);
               err_q  <= cmd_illegal;
            end
            SHIFT: begin
               work_q <= step_val;
               cnt_q  <= cnt_q - AMT_W'(1);
            end
            default: ;
         endcase
      end
   end

   // Handshake outputs decode the state flop only: no path from cmd_valid/res_ready.
   assign cmd_ready = (state == IDLE);
   assign res_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign res_data  = work_q;
   assign res_err   = err_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed test-plan cases plus
// randomized commands compared against an arithmetic shift/rotate model.
module tb_shift_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_op;
   logic [7:0] cmd_data;
   logic [2:0] cmd_amt;
   logic       res_valid;
   logic       res_ready;
   logic [7:0] res_data;
   logic       res_err;
   logic       busy;

   int n_cmp = 0;
   int n_err = 0;

   shift_sequencer #(.WIDTH(8), .AMT_W(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_data  (cmd_data),
      .cmd_amt   (cmd_amt),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_err   (res_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Whole-amount shift computed in one go, not step by step.
   function automatic logic [7:0] ref_shift(input int op, input logic [7:0] d, input int amt);
      logic [7:0] t;
      int k;
      k = amt % 8;
      case (op)
         0: t = d << amt;
         1: t = d >> amt;
         2: t = 8'($signed(d) >>> amt);
         3: t = (d << k) | (d >> ((8 - k) % 8));
         4: t = (d >> k) | (d << ((8 - k) % 8));
         default: t = d;
      endcase
      return t;
   endfunction

   // Issue one command, measure edges to res_valid, optionally stall the result.
   task automatic run_cmd(input logic [2:0] op, input logic [7:0] d, input logic [2:0] amt,
                          input int hold, input bit inject);
      logic [7:0] exp_data;
      int exp_lat, lat;
      exp_data = ref_shift(int'(op), d, int'(amt));
      exp_lat  = (op > 3'd4) ? 0 : int'(amt);
      @(negedge clk);
      check("idle_ready", cmd_ready, 1'b1);
      cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_amt = amt;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      lat = 0;
      while (!res_valid && lat < 20) begin
         check("shift_lock", {busy, cmd_ready}, 2'b10);
         if (inject) begin
            cmd_valid = 1'b1; cmd_op = 3'($urandom_range(0, 4));
            cmd_data = ~d; cmd_amt = 3'($urandom);
         end
         @(posedge clk);
         @(negedge clk);
         cmd_valid = 1'b0;
         lat++;
      end
      check("latency", lat, exp_lat);
      check("res_data", res_data, exp_data);
      check("res_err", res_err, (op > 3'd4));
      for (int i = 0; i < hold; i++) begin
         cmd_valid = 1'b1;
         @(posedge clk);
         @(negedge clk);
         check("bp_hold", {res_valid, cmd_ready, res_data}, {2'b10, exp_data});
      end
      cmd_valid = 1'b0;
      res_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      res_ready = 1'b0;
      check("back_idle", {res_valid, busy, cmd_ready}, 3'b001);
   endtask

   initial begin
      rst_n = 1'b0; res_ready = 1'b0;
      cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; cmd_amt = '0;

      // Reset with random inputs toggling.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         cmd_valid = 1'($urandom); cmd_op = 3'($urandom); cmd_data = 8'($urandom);
         cmd_amt = 3'($urandom); res_ready = 1'($urandom);
         #1 check("rst_outs", {res_valid, res_data, res_err, busy}, 11'd0);
      end
      @(negedge clk);
      cmd_valid = 1'b0; res_ready = 1'b0;
      rst_n = 1'b1;
      #1 check("rel_ready", cmd_ready, 1'b1);

      // Single steps on 0xEB.
      run_cmd(3'd0, 8'hEB, 3'd1, 0, 0);
      check("lsl1_lit", ref_shift(0, 8'hEB, 1), 8'hD6);
      run_cmd(3'd1, 8'hEB, 3'd1, 0, 0);
      run_cmd(3'd2, 8'hEB, 3'd1, 0, 0);
      run_cmd(3'd3, 8'hEB, 3'd1, 0, 0);
      run_cmd(3'd4, 8'hEB, 3'd1, 0, 0);
      // Multi-step and saturation.
      run_cmd(3'd0, 8'hEB, 3'd3, 0, 0);
      run_cmd(3'd4, 8'hEB, 3'd3, 0, 0);
      run_cmd(3'd2, 8'hEB, 3'd7, 0, 0);
      run_cmd(3'd2, 8'h6B, 3'd7, 0, 0);
      // Edge commands.
      run_cmd(3'd3, 8'hFF, 3'd0, 0, 0);
      run_cmd(3'd6, 8'h3C, 3'd0, 0, 0);
      run_cmd(3'd7, 8'h3C, 3'd5, 0, 0);
      // Backpressure and lockout.
      run_cmd(3'd1, 8'hC3, 3'd2, 5, 0);
      run_cmd(3'd3, 8'h81, 3'd5, 0, 1);

      // Reset abort two cycles into an amt=7 shift.
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 3'd2; cmd_data = 8'hEB; cmd_amt = 3'd7;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1 check("abort_outs", {res_valid, res_data, busy}, 10'd0);
      res_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("abort_noval", res_valid, 1'b0);
      end
      res_ready = 1'b0;
      rst_n = 1'b1;
      #1 check("abort_ready", cmd_ready, 1'b1);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("abort_quiet", {res_valid, busy}, 2'b00);
      end
      run_cmd(3'd1, 8'h80, 3'd7, 0, 0);

      // Randomized commands, including illegal ops and stalls.
      for (int i = 0; i < 60; i++)
         run_cmd(3'($urandom), 8'($urandom), 3'($urandom),
                 int'($urandom_range(0, 3)), 1'($urandom));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
